mips_prog_loader: RTL
=====================

MIPS_PROG_LOADER -- requirements
Module: mips_prog_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, the memory word-address width (1024-word memory).
REQ-002 SHALL have parameter MAX_WORDS, default 1024, the largest accepted load count.
REQ-003 SHALL have one clock and an asynchronous active-low reset, both listed first.
REQ-004 SHALL have port clk1, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port start, input, 1 bit: a one-cycle pulse that begins a load session.
REQ-007 SHALL have port in_valid, input, 1 bit: the source presents in_data.
REQ-008 SHALL have port in_data, input, 32 bits: the header, program or checksum word.
REQ-009 SHALL have port in_ready, output, 1 bit: the loader accepts a word.
REQ-010 SHALL have port mem_we, output, 1 bit: the instruction/data memory write strobe.
REQ-011 SHALL have port mem_addr, output, ADDR_W bits: the memory word address.
REQ-012 SHALL have port mem_wdata, output, 32 bits: the memory write data.
REQ-013 SHALL have port core_run, output, 1 bit: releases the pipelined core from halt.
REQ-014 SHALL have port busy, output, 1 bit: a session is in progress.
REQ-015 SHALL have port error, output, 1 bit: the last session failed.
REQ-016 SHALL have port words_loaded, output, 11 bits: the number of program words written in the current or last session.

Function
REQ-017 SHALL implement the states IDLE, HDR, LOAD, CHK, DONE and ERR.
REQ-018 SHALL complete a transfer only on a cycle with in_valid=1 and in_ready=1.
REQ-019 SHALL drive in_ready=1 only in HDR, LOAD and CHK, as a combinational decode of the state.
REQ-020 SHALL move from IDLE, DONE or ERR to HDR on start, clearing core_run, error and words_loaded.
REQ-021 SHALL ignore start while in HDR, LOAD or CHK.
REQ-022 SHALL decode the header word in HDR as base = in_data[25:16] and count = in_data[10:0].
REQ-023 SHALL go from HDR to ERR when count=0 or count>MAX_WORDS, and otherwise to LOAD.
REQ-024 SHALL, for each word accepted in LOAD, assert mem_we for exactly one cycle on the following cycle, with mem_addr = (base+index) mod 2^ADDR_W and mem_wdata = that word.
REQ-025 SHALL let the address wrap from 1023 to 0 with no error.
REQ-026 SHALL start index at 0 and increment words_loaded by 1 on each LOAD transfer.
REQ-027 SHALL leave LOAD after the count-th transfer: to CHK if the checksum is enabled, otherwise to DONE.
REQ-028 SHALL, in CHK, go to DONE when the accepted word equals the running sum, and to ERR otherwise.
REQ-029 SHALL compute the running sum as the 32-bit modulo-2^32 sum of all LOAD words.
REQ-030 SHALL assert core_run the cycle after entry to DONE and hold it until the next start.
REQ-031 SHALL deassert in_ready in DONE.
REQ-032 SHALL assert error in ERR and hold it until the next start; core_run SHALL stay 0 in ERR.
REQ-033 SHALL assert busy exactly while in HDR, LOAD or CHK.
REQ-034 SHALL hold mem_we=0 in every cycle except those of REQ-024.
REQ-035 SHALL perform no memory write for the header or checksum word.
REQ-036 SHALL have no effect from a stall (in_valid=0) except holding state; stalls of any length SHALL be legal.

Reset
REQ-037 SHALL, on rst_n=0, immediately force state IDLE.
REQ-038 SHALL, on rst_n=0, immediately force in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, core_run=0, busy=0, error=0, words_loaded=0, running sum=0 and index=0.
REQ-039 SHALL abort any session on reset mid-load and write nothing further.
REQ-040 SHALL stay in IDLE after reset release until start.

Configuration
REQ-041 SHALL, when macro LOADER_CHECKSUM_EN is defined, include the CHK state and running-sum adder per REQ-028/029.
REQ-042 SHALL, when LOADER_CHECKSUM_EN is undefined, contain no CHK state or adder and go from LOAD directly to DONE after the count-th word.

Verification
REQ-043 SHALL cover this scenario: header 0x0005_0003, words 0x11,0x22,0x33, checksum 0x66 -> writes to addresses 5,6,7, then core_run=1, error=0, words_loaded=3.
REQ-044 SHALL cover this scenario: header 0x03FE_0004 with 4 words -> writes to addresses 1022,1023,0,1 (wrap).
REQ-045 SHALL cover this scenario: header count 0, or count 1025 (0x0000_0401) -> ERR with error=1, no mem_we, core_run=0.
REQ-046 SHALL cover this scenario: checksum 0x67 instead of 0x66 -> error=1, core_run=0; the next start clears error.
REQ-047 SHALL cover this scenario: in_valid toggling randomly mid-LOAD -> identical writes and order as the unstalled case.
REQ-048 SHALL cover this scenario: rst_n low after the 2nd of 3 words -> all outputs 0 immediately, no 3rd write, IDLE after release.

Source files
------------

// File: rtl/mips_prog_loader.sv
// Boot loader that streams a header, program words and an optional checksum into core memory.
// Optional feature: define LOADER_CHECKSUM_EN to add the CHK state and running-sum verification.
module mips_prog_loader #(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned MAX_WORDS = 1024
) (
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [31:0]       in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              core_run,
    output logic              busy,
    output logic              error,
    output logic [10:0]       words_loaded
);

    localparam int unsigned CNT_W = 11;

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, HDR, LOAD, CHK, DONE, ERR} state_t;
`else
    typedef enum logic [2:0] {IDLE, HDR, LOAD, DONE, ERR} state_t;
`endif

    state_t             state;
    logic [ADDR_W-1:0]  base;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   index;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0]        sum;
`endif

    logic               xfer;
    logic               last;
    logic [CNT_W-1:0]   hdr_count;
    logic               hdr_bad;

    // Ready is a pure decode of the state so the source sees it without latency.
`ifdef LOADER_CHECKSUM_EN
    assign in_ready = (state == HDR) || (state == LOAD) || (state == CHK);
`else
    assign in_ready = (state == HDR) || (state == LOAD);
`endif

    assign xfer      = in_valid && in_ready;
    assign last      = (CNT_W'(index + CNT_W'(1)) == count);
    assign hdr_count = in_data[10:0];
    assign hdr_bad   = (hdr_count == CNT_W'(0)) || (32'(hdr_count) > 32'(MAX_WORDS));

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            base         <= '0;
            count        <= '0;
            index        <= '0;
`ifdef LOADER_CHECKSUM_EN
            sum          <= '0;
`endif
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            core_run     <= 1'b0;
            busy         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                IDLE, DONE, ERR: begin
                    // core_run rises one cycle after DONE is entered and stays until restart
                    if (state == DONE) begin
                        core_run <= 1'b1;
                    end
                    if (start) begin
                        state        <= HDR;
                        busy         <= 1'b1;
                        core_run     <= 1'b0;
                        error        <= 1'b0;
                        words_loaded <= '0;
                        index        <= '0;
`ifdef LOADER_CHECKSUM_EN
                        sum          <= '0;
`endif
                    end
                end
                HDR: begin
                    if (xfer) begin
                        base  <= ADDR_W'(in_data[25:16]);
                        count <= hdr_count;
                        if (hdr_bad) begin
                            state <= ERR;
                            busy  <= 1'b0;
                            error <= 1'b1;
                        end else begin
                            state <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (xfer) begin
                        mem_we       <= 1'b1;
                        mem_addr     <= base + ADDR_W'(index);
                        mem_wdata    <= in_data;
                        index        <= CNT_W'(index + CNT_W'(1));
                        words_loaded <= CNT_W'(words_loaded + CNT_W'(1));
`ifdef LOADER_CHECKSUM_EN
                        sum          <= sum + in_data;
                        if (last) begin
                            state <= CHK;
                        end
`else
                        if (last) begin
                            state <= DONE;
                            busy  <= 1'b0;
                        end
`endif
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                CHK: begin
                    if (xfer) begin
                        busy <= 1'b0;
                        if (in_data == sum) begin
                            state <= DONE;
                        end else begin
                            state <= ERR;
                            error <= 1'b1;
                        end
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule
